// File: rtl/wb_select_reg.sv
// wb_select_reg: registered write-back source selector for the multicycle
// MIPS datapath. It picks one of NSRC packed sources, applies partial-load
// extraction and extension to the memory (MDR) source, and registers the
// result together with the destination index and the register-file write
// enable. Writes to $zero are suppressed. An illegal select or a reserved
// load mode zeroes the data, blocks the write and pulses sel_err.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   src_flat   NSRC packed sources, source i at [i*WIDTH +: WIDTH]
//   sel        source select
//   load_mode  00 word, 01 half, 10 byte, 11 reserved (MEM_IDX only)
//   load_sext  1 sign-extend partial loads, 0 zero-extend
//   byte_off   address low bits for partial loads
//   dest_in    destination register index
//   wr_req     write-back request
//   stall      hold all registered outputs
//   flush      cancel pending write (data/dest hold)
//   wb_data    registered write data
//   wb_dest    registered destination
//   wb_we      registered write enable
//   sel_err    pulse on illegal select / reserved mode with wr_req

// Partial-load extraction for the memory source. Assumes WIDTH >= 32.
module wb_load_extract #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       mode,
    input  logic             sext,
    input  logic [1:0]       byte_off,
    output logic [WIDTH-1:0] data
);
    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        half   = byte_off[1] ? word[31:16] : word[15:0];
        byte_v = 8'h00;
        case (byte_off)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = 8'h00;
        endcase
        data = word;
        case (mode)
            2'b01:   data = {{(WIDTH-16){sext & half[15]}}, half};
            2'b10:   data = {{(WIDTH-8){sext & byte_v[7]}}, byte_v};
            default: data = word;  // word load; reserved is zeroed upstream
        endcase
    end
endmodule

module wb_select_reg #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 9,
    parameter int SELW    = 4,
    parameter int MEM_IDX = 1,
    parameter int REGW    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRC*WIDTH-1:0] src_flat,
    input  logic [SELW-1:0]       sel,
    input  logic [1:0]            load_mode,
    input  logic                  load_sext,
    input  logic [1:0]            byte_off,
    input  logic [REGW-1:0]       dest_in,
    input  logic                  wr_req,
    input  logic                  stall,
    input  logic                  flush,
    output logic [WIDTH-1:0]      wb_data,
    output logic [REGW-1:0]       wb_dest,
    output logic                  wb_we,
    output logic                  sel_err
);
    // One extra bit so NSRC == 2**SELW still compares correctly.
    localparam logic [SELW:0]   NSRC_W  = NSRC[SELW:0];
    localparam logic [SELW-1:0] MEM_SEL = MEM_IDX[SELW-1:0];

    logic [WIDTH-1:0] src [NSRC];
    logic [WIDTH-1:0] picked;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] next_data;
    logic             is_mem;
    logic             in_range;
    logic             legal;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign src[i] = src_flat[i*WIDTH +: WIDTH];
    end

    wb_load_extract #(.WIDTH(WIDTH)) u_extract (
        .word     (src[MEM_IDX]),
        .mode     (load_mode),
        .sext     (load_sext),
        .byte_off (byte_off),
        .data     (mem_data)
    );

    // Explicit compare loop keeps out-of-range selects from indexing src.
    always_comb begin
        picked = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SELW'(i)) picked = src[i];
        end
    end

    assign is_mem    = (sel == MEM_SEL);
    assign in_range  = ({1'b0, sel} < NSRC_W);
    assign legal     = in_range && !(is_mem && load_mode == 2'b11);
    assign next_data = !legal ? '0 : (is_mem ? mem_data : picked);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data <= '0;
            wb_dest <= '0;
            wb_we   <= 1'b0;
            sel_err <= 1'b0;
        end else if (flush) begin
            wb_we   <= 1'b0;
            sel_err <= 1'b0;
        end else if (!stall) begin
            wb_data <= next_data;
            wb_dest <= dest_in;
            wb_we   <= wr_req & legal & (|dest_in);
            sel_err <= wr_req & ~legal;
        end
    end
endmodule
